seven_seg_scan: RTL
===================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, default 2, giving all-anodes-off clocks inserted after each digit switch (legal 0..15).
REQ-002 The block SHALL have parameter ZERO_SUPPRESS, default 0, where 1 blanks leading zero digits.
REQ-003 Port clk_24M  input  1  sole clock, 24 MHz; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port anode_tick  input  1  single-cycle enable pulse at 10 kHz from the clock divider; never a clock.
REQ-006 Port value  input  16  four hex nibbles; digit 0 (rightmost) = value[3:0], digit 3 = value[15:12].
REQ-007 Port dp_in  input  4  decimal point request per digit, bit k = digit k.
REQ-008 Port blank_in  input  4  force-blank per digit, bit k = digit k.
REQ-009 Port an_n  output  4  active-low anode enables, bit k = digit k; registered.
REQ-010 Port seg_n  output  7  active-low segments, bit 0 = a ... bit 6 = g; registered.
REQ-011 Port dp_n  output  1  active-low decimal point; registered.
REQ-012 Port frame_start  output  1  one-cycle pulse when a new scan frame begins; registered.

Function
REQ-013 A 2-bit digit index SHALL advance by one on each anode_tick, wrapping 3 -> 0; no other event changes it.
REQ-014 On an anode_tick that wraps the index to 0, value, dp_in and blank_in SHALL be captured into shadow registers; outputs SHALL use only shadow values, so a frame never tears.
REQ-015 frame_start SHALL be high exactly in the cycle after a wrapping anode_tick.
REQ-016 States SHALL be OFF, DEAD, DRIVE; reset enters OFF; any anode_tick from any state enters DEAD with dead counter loaded to DEAD_CYCLES, or DRIVE directly if DEAD_CYCLES = 0.
REQ-017 In DEAD, the counter SHALL decrement each clock; on the clock where it reaches 0, state SHALL become DRIVE.
REQ-018 Tick at cycle T: at T+1 an_n = 4'b1111 and seg_n/dp_n already show the new digit; at T+1+DEAD_CYCLES an_n drives the new digit low.
REQ-019 An anode_tick during DEAD SHALL advance the index and restart the dead period (no digit skipped from the index sequence).
REQ-020 In DRIVE, exactly one an_n bit (the current index) SHALL be low unless the digit is blanked; in OFF and DEAD, an_n SHALL be 4'b1111.
REQ-021 Decode (seg_n hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-022 dp_n SHALL be ~dp_shadow[index] for non-blanked digits, else 1.
REQ-023 A digit SHALL be blanked (an_n bit high, seg_n = 7F, dp_n = 1) if blank_shadow[k] = 1, or if ZERO_SUPPRESS = 1, k != 0, and shadow nibbles k..3 are all zero.
REQ-024 Digit 0 SHALL never be zero-suppressed (value 0 shows "0").

Reset
REQ-025 Reset SHALL force: state OFF, index 3 (first tick wraps to 0 and captures), shadows 0, dead counter 0, an_n = 4'b1111, seg_n = 7'h7F, dp_n = 1, frame_start = 0.
REQ-026 Reset SHALL override a simultaneous anode_tick; reset asserted mid-DEAD or mid-DRIVE SHALL produce reset values on the next clock.

Structure
REQ-027 Shared package SHALL hold the state enum, the 16-entry segment decode constants and the digit-count constant (4).
REQ-028 Decode SHALL be a combinational sub-module hex_to_7seg (4-bit in, 7-bit active-low out), instantiated once on the selected shadow nibble.

Verification
REQ-029 Reset then value=16'h1234, DEAD_CYCLES=2, four ticks -> frame_start after first tick; digits 0..3 show seg_n 19,30,24,79 with an_n 1110,1101,1011,0111, each going low 3 cycles after its tick.
REQ-030 value changed to 16'hABCD between ticks 2 and 3 of a frame -> remaining digits of that frame still show 1234 nibbles; next frame shows 08,03,46,21 order d,C,b,A.
REQ-031 ZERO_SUPPRESS=1, value=16'h0005 -> digits 3..1 an_n bit stays high, seg_n 7F; digit 0 shows 12; value=16'h0000 shows only "0" (seg_n 40).
REQ-032 DEAD_CYCLES=0, ticks on consecutive clocks -> index advances every cycle, an_n never has two bits low, no state lockup.
REQ-033 blank_in=4'b0100, dp_in=4'b0101 -> digit 2 fully dark with dp_n=1; digit 0 dp_n=0.
REQ-034 reset asserted with anode_tick in DEAD -> next cycle all reset values; following tick selects digit 0 and pulses frame_start.

Source files
------------

// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared state codes, digit count and segment table for the digit scanner
package seven_seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_OFF   = 2'd0;
  localparam state_t ST_DEAD  = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  // Active-low patterns indexed by hex digit, bit 0 = segment a.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to active-low seven-segment decode
module hex_to_7seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment scanner with dead time
// Frame inputs are shadowed on the wrapping tick so a frame never mixes two values.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int DEAD_CYCLES   = 2,
  parameter int ZERO_SUPPRESS = 0
) (
  input  logic        clk_24M,
  input  logic        reset,
  input  logic        anode_tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES);
  localparam logic [1:0] LAST_IDX  = 2'(NUM_DIGITS - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  dead_q, dead_d;
  logic [15:0] val_sh_q, val_sh_d;
  logic [3:0]  dp_sh_q, dp_sh_d;
  logic [3:0]  blank_sh_q, blank_sh_d;
  logic [3:0]  an_n_q, an_n_d;
  logic [6:0]  seg_n_q, seg_n_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_start_q, frame_start_d;

  logic        wrap;
  logic [3:0]  zs_blank;
  logic        digit_blank;
  logic [3:0]  nibble;
  logic [6:0]  dec_seg_n;

  assign wrap = anode_tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d      = idx_q;
    state_d    = state_q;
    dead_d     = dead_q;
    val_sh_d   = val_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    if (anode_tick) begin
      idx_d = idx_q + 2'd1;
      if (DEAD_CYCLES == 0) begin
        state_d = ST_DRIVE;
        dead_d  = 4'd0;
      end else begin
        state_d = ST_DEAD;
        dead_d  = DEAD_LOAD;
      end
      if (wrap) begin
        val_sh_d   = value;
        dp_sh_d    = dp_in;
        blank_sh_d = blank_in;
      end
    end else if (state_q == ST_DEAD) begin
      if (dead_q <= 4'd1) begin
        dead_d  = 4'd0;
        state_d = ST_DRIVE;
      end else begin
        dead_d = dead_q - 4'd1;
      end
    end
  end

  // Outputs are registered from next-state values so the new digit shows one clock after the tick.
  always_comb begin
    zs_blank[0] = 1'b0;
    zs_blank[1] = (ZERO_SUPPRESS != 0) && (val_sh_d[15:4] == 12'h000);
    zs_blank[2] = (ZERO_SUPPRESS != 0) && (val_sh_d[15:8] == 8'h00);
    zs_blank[3] = (ZERO_SUPPRESS != 0) && (val_sh_d[15:12] == 4'h0);
    digit_blank = blank_sh_d[idx_d] || zs_blank[idx_d] || (state_d == ST_OFF);
    an_n_d = 4'hF;
    if ((state_d == ST_DRIVE) && !digit_blank) begin
      an_n_d[idx_d] = 1'b0;
    end
    seg_n_d       = digit_blank ? 7'h7F : dec_seg_n;
    dp_n_d        = digit_blank ? 1'b1 : ~dp_sh_d[idx_d];
    frame_start_d = wrap;
  end

  assign nibble = val_sh_d[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex   (nibble),
    .seg_n (dec_seg_n)
  );

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state_q       <= ST_OFF;
      idx_q         <= LAST_IDX;
      dead_q        <= 4'd0;
      val_sh_q      <= 16'h0000;
      dp_sh_q       <= 4'h0;
      blank_sh_q    <= 4'h0;
      an_n_q        <= 4'hF;
      seg_n_q       <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dead_q        <= dead_d;
      val_sh_q      <= val_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule
